// File: rtl/msx_mouse_port.sv
// msx_mouse_port: shares one MSX joystick port between a DB9 joystick
// and a PS/2 mouse, serving mouse deltas as strobe-sequenced nibbles.
module msx_mouse_port #(
  parameter int TIMEOUT = 100000,
  parameter int TO_W    = 18
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [5:0] joy_in,
  input  logic [8:0] mouse_dx,
  input  logic [8:0] mouse_dy,
  input  logic [1:0] mouse_btn,
  input  logic       mouse_strobe,
  input  logic       stra,
  output logic [5:0] port_out,
  output logic       mouse_en,
  output logic [1:0] seq_state
);

  typedef enum logic [1:0] {
    S_XH = 2'd0,
    S_XL = 2'd1,
    S_YH = 2'd2,
    S_YL = 2'd3
  } seq_e;

  seq_e            seq_q, seq_d;
  logic [5:0]      port_q, port_d;
  logic            en_q, en_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            stra_q, stra_d;
  logic [7:0]      acc_x_q, acc_x_d;
  logic [7:0]      acc_y_q, acc_y_d;
  logic [7:0]      xfer_x_q, xfer_x_d;
  logic [7:0]      xfer_y_q, xfer_y_d;

  logic            act;
  logic [7:0]      base_x, base_y;

  // Signed add in 10 bits, clamped to [-128, +127].
  function automatic logic [7:0] sat8(
    input logic [7:0] a,
    input logic [8:0] d
  );
    logic [9:0] s;
    s = {{2{a[7]}}, a} + {d[8], d};
    if (!s[9] && s[8:7] != 2'b00)
      sat8 = 8'h7F;
    else if (s[9] && s[8:7] != 2'b11)
      sat8 = 8'h80;
    else
      sat8 = s[7:0];
  endfunction

  // The MSX reads each nibble with its MSB on port bit 0.
  function automatic logic [3:0] rev4(input logic [3:0] n);
    rev4 = {n[0], n[1], n[2], n[3]};
  endfunction

  // Next-state: ownership, accumulation, nibble sequencing, timeout.
  always_comb begin
    seq_d    = seq_q;
    port_d   = port_q;
    en_d     = en_q;
    to_d     = to_q;
    stra_d   = stra;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    xfer_x_d = xfer_x_q;
    xfer_y_d = xfer_y_q;
    base_x   = acc_x_q;
    base_y   = acc_y_q;
    act      = (stra ^ stra_q) & en_q;

    if (mouse_strobe)
      en_d = 1'b1;
    else if (joy_in != 6'h3F)
      en_d = 1'b0;

    if (act && seq_q == S_XH) begin
      xfer_x_d = acc_x_q;
      xfer_y_d = acc_y_q;
      base_x   = 8'h00;
      base_y   = 8'h00;
    end

    if (mouse_strobe) begin
      acc_x_d = sat8(base_x, mouse_dx);
      acc_y_d = sat8(base_y, mouse_dy);
    end else begin
      acc_x_d = base_x;
      acc_y_d = base_y;
    end

    if (!en_q) begin
      port_d = joy_in;
    end else begin
      port_d[5:4] = ~mouse_btn;
      if (act) begin
        unique case (seq_q)
          S_XH: port_d[3:0] = rev4(acc_x_q[7:4]);
          S_XL: port_d[3:0] = rev4(xfer_x_q[3:0]);
          S_YH: port_d[3:0] = rev4(xfer_y_q[7:4]);
          S_YL: port_d[3:0] = rev4(xfer_y_q[3:0]);
        endcase
      end
    end

    if (act) begin
      seq_d = seq_e'(seq_q + 2'd1);
      to_d  = TO_W'(TIMEOUT);
    end else if (to_q != '0) begin
      to_d = to_q - TO_W'(1);
      if (to_q == TO_W'(1))
        seq_d = S_XH;
    end

    if (en_q && !en_d) begin
      seq_d = S_XH;
      to_d  = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      seq_q    <= S_XH;
      port_q   <= 6'h3F;
      en_q     <= 1'b0;
      to_q     <= '0;
      stra_q   <= 1'b0;
      acc_x_q  <= 8'h00;
      acc_y_q  <= 8'h00;
      xfer_x_q <= 8'h00;
      xfer_y_q <= 8'h00;
    end else begin
      seq_q    <= seq_d;
      port_q   <= port_d;
      en_q     <= en_d;
      to_q     <= to_d;
      stra_q   <= stra_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      xfer_x_q <= xfer_x_d;
      xfer_y_q <= xfer_y_d;
    end
  end

  assign port_out  = port_q;
  assign mouse_en  = en_q;
  assign seq_state = seq_q;

endmodule

// File: tb/tb_msx_mouse_port.sv
// tb_msx_mouse_port: directed checks of joystick pass-through, mouse
// nibble readout, saturation, timeout, ownership and async reset.
module tb_msx_mouse_port;

  localparam int TO = 50;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [5:0] joy_in;
  logic [8:0] mouse_dx;
  logic [8:0] mouse_dy;
  logic [1:0] mouse_btn;
  logic       mouse_strobe;
  logic       stra;
  logic [5:0] port_out;
  logic       mouse_en;
  logic [1:0] seq_state;

  int errors = 0;
  int checks = 0;

  msx_mouse_port #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .joy_in       (joy_in),
    .mouse_dx     (mouse_dx),
    .mouse_dy     (mouse_dy),
    .mouse_btn    (mouse_btn),
    .mouse_strobe (mouse_strobe),
    .stra         (stra),
    .port_out     (port_out),
    .mouse_en     (mouse_en),
    .seq_state    (seq_state)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic toggle_read(input string tag, input logic [5:0] p,
                             input logic [1:0] s);
    stra = ~stra;
    step();
    chk({tag, "_port"}, {2'b00, port_out}, {2'b00, p});
    chk({tag, "_seq"}, {6'b0, seq_state}, {6'b0, s});
  endtask

  initial begin
    reset = 1'b1;
    joy_in = 6'h3F;
    mouse_dx = '0;
    mouse_dy = '0;
    mouse_btn = '0;
    mouse_strobe = 1'b0;
    stra = 1'b0;
    step();
    step();
    chk("rst_port", {2'b00, port_out}, 8'h3F);
    chk("rst_en", {7'b0, mouse_en}, 8'h00);
    chk("rst_seq", {6'b0, seq_state}, 8'h00);
    reset = 1'b0;
    step();

    joy_in = 6'h3E;
    step();
    chk("joy_port", {2'b00, port_out}, 8'h3E);
    chk("joy_en", {7'b0, mouse_en}, 8'h00);
    joy_in = 6'h3F;
    step();

    mouse_dx = 9'd5;
    mouse_dy = 9'h1FD;
    mouse_btn = 2'b01;
    mouse_strobe = 1'b1;
    step();
    mouse_strobe = 1'b0;
    chk("pkt_en", {7'b0, mouse_en}, 8'h01);
    toggle_read("n0", 6'h20, 2'd1);
    toggle_read("n1", 6'h2A, 2'd2);
    toggle_read("n2", 6'h2F, 2'd3);
    toggle_read("n3", 6'h2B, 2'd0);

    mouse_dx = 9'd100;
    mouse_dy = 9'd0;
    mouse_btn = 2'b00;
    mouse_strobe = 1'b1;
    repeat (3) step();
    mouse_strobe = 1'b0;
    toggle_read("sat_xh", 6'h3E, 2'd1);
    toggle_read("sat_xl", 6'h3F, 2'd2);
    toggle_read("sat_yh", 6'h30, 2'd3);
    toggle_read("sat_yl", 6'h30, 2'd0);
    toggle_read("clr_xh", 6'h30, 2'd1);
    toggle_read("clr_xl", 6'h30, 2'd2);
    toggle_read("clr_yh", 6'h30, 2'd3);
    toggle_read("clr_yl", 6'h30, 2'd0);

    mouse_dx = 9'h1FF;
    mouse_dy = 9'd2;
    mouse_strobe = 1'b1;
    step();
    mouse_strobe = 1'b0;
    toggle_read("to_xh", 6'h3F, 2'd1);
    toggle_read("to_xl", 6'h3F, 2'd2);
    repeat (TO - 1) step();
    chk("to_before", {6'b0, seq_state}, 8'h02);
    step();
    chk("to_expire", {6'b0, seq_state}, 8'h00);
    mouse_dx = 9'h030;
    mouse_dy = 9'd0;
    mouse_strobe = 1'b1;
    step();
    mouse_strobe = 1'b0;
    toggle_read("to_fresh", 6'h3C, 2'd1);

    joy_in = 6'h3E;
    step();
    chk("own_clr_en", {7'b0, mouse_en}, 8'h00);
    chk("own_clr_seq", {6'b0, seq_state}, 8'h00);
    step();
    chk("own_joy", {2'b00, port_out}, 8'h3E);
    mouse_dx = 9'd0;
    mouse_strobe = 1'b1;
    step();
    chk("own_win", {7'b0, mouse_en}, 8'h01);
    mouse_strobe = 1'b0;
    joy_in = 6'h3F;
    step();
    chk("own_keep", {7'b0, mouse_en}, 8'h01);

    mouse_dx = 9'd5;
    mouse_dy = 9'h1FD;
    mouse_btn = 2'b01;
    mouse_strobe = 1'b1;
    step();
    mouse_strobe = 1'b0;
    toggle_read("mr_n0", 6'h20, 2'd1);
    toggle_read("mr_n1", 6'h2A, 2'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_port", {2'b00, port_out}, 8'h3F);
    chk("arst_en", {7'b0, mouse_en}, 8'h00);
    chk("arst_seq", {6'b0, seq_state}, 8'h00);
    step();
    reset = 1'b0;
    step();
    toggle_read("post_rst", 6'h3F, 2'd0);
    chk("post_rst_en", {7'b0, mouse_en}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
